// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: default sizes, FSM states
// and the digit-counter width helper.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIGIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to hold the full digit count, not just its last index.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit borrow-ripple slice: d = a_d - b_d - bw_i, built as a_d + ~b_d + ~bw_i.
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bw_i,
    output logic [DIGIT-1:0] d,
    output logic             bw_o
);

    logic [DIGIT:0] sum;

    // A missing carry out of the complement-add means a borrow was needed.
    assign sum  = {1'b0, a_d} + {1'b0, ~b_d} + {{DIGIT{1'b0}}, ~bw_i};
    assign d    = sum[DIGIT-1:0];
    assign bw_o = ~sum[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor, diff = a - b - bw_in, LSB digit first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bw_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bw_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW         = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] d;
    logic             bw_o;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] diff_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    sub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_d (a_sh[DIGIT-1:0]),
        .b_d (b_sh[DIGIT-1:0]),
        .bw_i(borrow),
        .d   (d),
        .bw_o(bw_o)
    );

    // New digits enter at the MSB end so the last digit lands in the top slot.
    assign d_ext     = WIDTH'(d) << (WIDTH - DIGIT);
    assign diff_next = (diff >> DIGIT) | d_ext;
    assign in_ready  = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bw_out    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bw_in;
                        cnt    <= '0;
                        state  <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    diff   <= diff_next;
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    borrow <= bw_o;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_DIGIT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bw_out    <= bw_o;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf       <= (a_msb != b_msb) && (d[DIGIT-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a DIGIT=1 and a DIGIT=4 instance checked
// against a plain-arithmetic model; ovf is checked when SERIAL_SUBTRACTOR_OVF_EN is set.
module tb_serial_subtractor;

    typedef struct {
        logic [15:0] diff;
        logic        bw;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bw_in = 1'b0;

    logic        in_valid_1 = 1'b0, out_ready_1 = 1'b1;
    logic        in_ready_1, out_valid_1, bw_out_1, ovf_1;
    logic [15:0] diff_1;
    logic        in_valid_4 = 1'b0, out_ready_4 = 1'b1;
    logic        in_ready_4, out_valid_4, bw_out_4, ovf_4;
    logic [15:0] diff_4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q1[$];
    exp_t exp_q4[$];
    logic prev_valid_1 = 1'b0;
    logic prev_valid_4 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .a(a), .b(b), .bw_in(bw_in), .out_valid(out_valid_1), .out_ready(out_ready_1),
        .diff(diff_1), .bw_out(bw_out_1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf_1)
`endif
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a), .b(b), .bw_in(bw_in), .out_valid(out_valid_4), .out_ready(out_ready_4),
        .diff(diff_4), .bw_out(bw_out_4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf_4)
`endif
    );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf_1 = 1'b0;
    assign ovf_4 = 1'b0;
`endif

    // Reference: true integer difference, then wrap; overflow from the signed range.
    function automatic exp_t model(input logic [15:0] a_v, input logic [15:0] b_v, input logic bw_v);
        exp_t e;
        int   r;
        int   sr;
        r  = int'(a_v) - int'(b_v) - int'(bw_v);
        sr = int'($signed(a_v)) - int'($signed(b_v)) - int'(bw_v);
        e.diff = r[15:0];
        e.bw   = (r < 0);
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.acc  = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [15:0] a_v, input logic [15:0] b_v,
                                 input logic bw_v);
        exp_t e;
        int   n;
        n = 0;
        while (((sel == 0) ? in_ready_1 : in_ready_4) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) checkOutput("in_ready_timeout", 0, 1);
        a = a_v;
        b = b_v;
        bw_in = bw_v;
        if (sel == 0) in_valid_1 = 1'b1; else in_valid_4 = 1'b1;
        @(posedge clk); #1;
        in_valid_1 = 1'b0;
        in_valid_4 = 1'b0;
        e = model(a_v, b_v, bw_v);
        e.acc = cyc;
        if (sel == 0) exp_q1.push_back(e); else exp_q4.push_back(e);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q1.size() != 0 || exp_q4.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) checkOutput("drain_timeout", 0, 1);
    endtask

    // Monitors: every valid cycle is compared with the head, popped on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid_1 = 1'b0;
        end else begin
            if (out_valid_1) begin
                if (exp_q1.size() == 0) begin
                    checkOutput("dut1_unexpected_valid", 1, 0);
                end else begin
                    if (!prev_valid_1) checkOutput("dut1_latency", cyc - exp_q1[0].acc, 16);
                    checkOutput("dut1_diff", int'(diff_1), int'(exp_q1[0].diff));
                    checkOutput("dut1_bw_out", int'(bw_out_1), int'(exp_q1[0].bw));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    checkOutput("dut1_ovf", int'(ovf_1), int'(exp_q1[0].ovf));
`endif
                    if (out_ready_1) void'(exp_q1.pop_front());
                end
            end
            prev_valid_1 = out_valid_1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid_4 = 1'b0;
        end else begin
            if (out_valid_4) begin
                if (exp_q4.size() == 0) begin
                    checkOutput("dut4_unexpected_valid", 1, 0);
                end else begin
                    if (!prev_valid_4) checkOutput("dut4_latency", cyc - exp_q4[0].acc, 4);
                    checkOutput("dut4_diff", int'(diff_4), int'(exp_q4[0].diff));
                    checkOutput("dut4_bw_out", int'(bw_out_4), int'(exp_q4[0].bw));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    checkOutput("dut4_ovf", int'(ovf_4), int'(exp_q4[0].ovf));
`endif
                    if (out_ready_4) void'(exp_q4.pop_front());
                end
            end
            prev_valid_4 = out_valid_4;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t bp_exp;
        int   n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(out_valid_1), 0);
        checkOutput("reset_diff", int'(diff_1), 0);
        checkOutput("reset_bw_out", int'(bw_out_1), 0);
        checkOutput("reset_in_ready", int'(in_ready_1), 0);
        checkOutput("reset_in_ready_dut4", int'(in_ready_4), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", int'(in_ready_1), 1);

        $display("[TB] directed cases on DIGIT=1");
        applyStimulus(0, 16'h1234, 16'h0034, 1'b0);
        applyStimulus(0, 16'h0000, 16'h0001, 1'b0);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b1);
        waitDrain();

        $display("[TB] backpressure on DIGIT=1");
        out_ready_1 = 1'b0;
        bp_exp = model(16'hA5C3, 16'h3C5A, 1'b1);
        applyStimulus(0, 16'hA5C3, 16'h3C5A, 1'b1);
        n = 0;
        while (out_valid_1 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) checkOutput("bp_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready_low", int'(in_ready_1), 0);
            a = 16'($urandom);
            b = 16'($urandom);
            bw_in = 1'($urandom);
            in_valid_1 = 1'b1;
            @(posedge clk); #1;
            in_valid_1 = 1'b0;
        end
        out_ready_1 = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_out_valid", int'(out_valid_1), 0);
        checkOutput("bp_release_in_ready", int'(in_ready_1), 1);
        checkOutput("bp_diff_kept", int'(diff_1), int'(bp_exp.diff));
        checkOutput("bp_bw_kept", int'(bw_out_1), int'(bp_exp.bw));

        $display("[TB] reset during RUN on DIGIT=1");
        applyStimulus(0, 16'hFFFF, 16'h1111, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q1.delete();
        exp_q4.delete();
        @(posedge clk); #1;
        checkOutput("midrun_out_valid", int'(out_valid_1), 0);
        checkOutput("midrun_diff", int'(diff_1), 0);
        checkOutput("midrun_bw_out", int'(bw_out_1), 0);
        checkOutput("midrun_in_ready_in_rst", int'(in_ready_1), 0);
        rst = 1'b0;
        #1;
        checkOutput("midrun_in_ready_after", int'(in_ready_1), 1);
        applyStimulus(0, 16'h0005, 16'h0003, 1'b0);
        waitDrain();

        $display("[TB] DIGIT=4 corner and back-to-back random");
        applyStimulus(1, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        waitDrain();

        $display("[TB] random on DIGIT=1");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        applyStimulus(0, 16'h7FFF, 16'hFFFF, 1'b0);
        applyStimulus(0, 16'h0000, 16'h0000, 1'b1);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial two's-complement subtractor computing diff = a - b - bw_in; the subtract-side counterpart to the team's combinational 16-bit ripple adder.
- Processes DIGIT bits per clock, LSB digit first, trading latency for area.
- Sits between an operand producer and a result consumer, each on a valid/ready handshake.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 1, bits processed per cycle; must divide WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bw_in  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bw_in, modulo 2^WIDTH.
- bw_out  output  1  borrow out; 1 iff unsigned a < b + bw_in.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, diff=0, bw_out=0, state=IDLE, digit counter=0. in_ready=0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- IDLE:
  - On in_valid && in_ready, capture a, b and bw_in into shift registers, clear the counter, go to RUN.
  - Operands are sampled only on the accept edge. Later changes to the inputs are ignored.
- RUN:
  - Each edge processes one digit: d = a_lo - b_lo - borrow, computed as a_lo + ~b_lo + ~borrow.
  - Shift d into diff from the MSB side, shift the operand registers right by DIGIT, and update borrow.
  - After WIDTH/DIGIT RUN edges, go to DONE and set out_valid=1. bw_out takes the final borrow.
- Latency: out_valid is high exactly WIDTH/DIGIT edges after the accepting edge (16 edges at the defaults).
- diff must not be observed as valid until out_valid=1. Intermediate values of diff are unspecified.
- DONE:
  - diff, bw_out and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready, clear out_valid and go to IDLE. diff and bw_out keep their values.
  - in_ready rises on the following cycle. There is no same-cycle accept and release.
- in_valid is ignored in RUN and DONE. Inputs are not queued.
- Reset mid-operation (RUN or DONE): the transaction is abandoned and all outputs take their reset values on that edge.
- Wrap-around: diff is always modulo 2^WIDTH. Borrow-out semantics are unsigned.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port ovf (1 bit), valid with out_valid.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]). This is signed overflow; bw_in is included in diff.
  - ovf resets to 0 and holds with diff.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package sub_pkg:
  - Default WIDTH/DIGIT localparams.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width function clog2(WIDTH/DIGIT + 1).
- Sub-module sub_digit: combinational DIGIT-bit borrow-ripple slice.
  - Inputs: a_d, b_d, bw_i. Outputs: d, bw_o.
  - Instantiated once in serial_subtractor.

Test Plan:
- Basic case: a=0x1234, b=0x0034, bw_in=0 -> diff=0x1200, bw_out=0. out_valid exactly 16 edges after accept.
- Underflow: a=0x0000, b=0x0001, bw_in=0 -> diff=0xFFFF, bw_out=1. With SERIAL_SUBTRACTOR_OVF_EN, ovf=0.
- Signed overflow: a=0x8000, b=0x0001, bw_in=1 -> diff=0x7FFE, bw_out=0. ovf=1 when enabled.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands.
  - diff and bw_out stay stable; in_ready=0; the new operands are not accepted.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at the 7th RUN edge -> out_valid=0, diff=0, in_ready=1 after rst falls.
  - A following a=0x0005, b=0x0003 gives diff=0x0002.
- DIGIT=4: a=0xFFFF, b=0xFFFF, bw_in=1 -> diff=0xFFFF, bw_out=1, out_valid 4 edges after accept.
  - Also run back-to-back transactions with out_ready tied high; each must give the correct result.
